step_motor_phase_gen: RTL and testbench

- Generates the four coil-drive signals (AX, AY, BX, BY) that the board top level inverts and routes to the microscope X/Y/Z stage drivers and the syringe driver.
- Sits directly upstream of those port pins and is instantiated once per axis.
- Accepts a move command (step count, direction, step period), sequences full-step or half-step phase patterns and tracks signed position.
- Stops early on a limit switch in the direction of travel, or on an abort request.

---
 rtl/step_motor_phase_gen.sv | 189 ++++++++++++++++++
 tb/tb_step_motor_phase_gen.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/step_motor_phase_gen.sv
`default_nettype none
// ============================================================================
//  Module   : step_motor_phase_gen
//  Purpose  : Stepper coil phase sequencer (full/half step) with signed
//             position tracking, limit-switch stop and abort.
//  Revision : 1.0 - initial release
// ============================================================================
module step_motor_phase_gen #(
    parameter int CNT_W = 16,
    parameter int POS_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_period,
    input  logic             half_step,
    input  logic             hold_en,
    input  logic             abort,
    input  logic             pos_clr,
    input  logic             limit_pos,
    input  logic             limit_neg,
    output logic             AX,
    output logic             AY,
    output logic             BX,
    output logic             BY,
    output logic             busy,
    output logic             done,
    output logic             fault_limit,
    output logic [POS_W-1:0] position
);

    localparam logic [0:0]       c_IDLE     = 1'b0;
    localparam logic [0:0]       c_RUN      = 1'b1;
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_CNT_TWO  = CNT_W'(2);
    localparam logic [POS_W-1:0] c_POS_ONE  = POS_W'(1);
    localparam logic [POS_W-1:0] c_POS_TWO  = POS_W'(2);

    logic [0:0]       r_state;
    logic [2:0]       r_index;
    logic [POS_W-1:0] r_position;
    logic [CNT_W-1:0] r_steps_left;
    logic [CNT_W-1:0] r_period_cnt;
    logic [CNT_W-1:0] r_reload;
    logic             r_dir;
    logic             r_half;
    logic             r_done;
    logic             r_fault;
    logic [3:0]       r_coils;
    logic             r_lim_pos_meta, r_lim_pos_sync;
    logic             r_lim_neg_meta, r_lim_neg_sync;

    logic [0:0]       w_state_nxt;
    logic [2:0]       w_index_nxt;
    logic [POS_W-1:0] w_pos_nxt;
    logic [CNT_W-1:0] w_steps_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_reload_nxt;
    logic             w_dir_nxt;
    logic             w_half_nxt;
    logic             w_done_nxt;
    logic             w_fault_nxt;
    logic             w_accept;
    logic             w_limit_hit;
    logic [2:0]       w_idx_delta;
    logic [POS_W-1:0] w_pos_delta;
    logic [CNT_W-1:0] w_cmd_reload;

    // Coil pattern {AX, AY, BX, BY} for each phase index
    function automatic logic [3:0] f_phase(input logic [2:0] idx);
        case (idx)
            3'd0:    f_phase = 4'b1000;
            3'd1:    f_phase = 4'b1010;
            3'd2:    f_phase = 4'b0010;
            3'd3:    f_phase = 4'b0110;
            3'd4:    f_phase = 4'b0100;
            3'd5:    f_phase = 4'b0101;
            3'd6:    f_phase = 4'b0001;
            default: f_phase = 4'b1001;
        endcase
    endfunction

    assign busy        = (r_state == c_RUN);
    assign cmd_ready   = ~busy & ~reset;
    assign done        = r_done;
    assign fault_limit = r_fault;
    assign position    = r_position;
    assign {AX, AY, BX, BY} = r_coils;

    assign w_accept     = cmd_valid & cmd_ready;
    assign w_limit_hit  = r_dir ? r_lim_pos_sync : r_lim_neg_sync;
    assign w_idx_delta  = r_half ? 3'd1 : 3'd2;
    assign w_pos_delta  = r_half ? c_POS_ONE : c_POS_TWO;
    assign w_cmd_reload = (cmd_period < c_CNT_TWO) ? c_CNT_ONE : (cmd_period - c_CNT_ONE);

    always_comb begin
        w_state_nxt  = r_state;
        w_index_nxt  = r_index;
        w_pos_nxt    = r_position;
        w_steps_nxt  = r_steps_left;
        w_cnt_nxt    = r_period_cnt;
        w_reload_nxt = r_reload;
        w_dir_nxt    = r_dir;
        w_half_nxt   = r_half;
        w_done_nxt   = 1'b0;
        w_fault_nxt  = r_fault;
        if (r_state == c_IDLE) begin
            if (pos_clr) begin
                w_pos_nxt = '0;
            end
            if (w_accept) begin
                w_dir_nxt    = cmd_dir;
                w_half_nxt   = half_step;
                w_reload_nxt = w_cmd_reload;
                w_cnt_nxt    = w_cmd_reload;
                w_steps_nxt  = cmd_steps;
                w_fault_nxt  = 1'b0;
                if (cmd_steps == '0) begin
                    w_done_nxt = 1'b1;
                end else begin
                    w_state_nxt = c_RUN;
                    // Full-step runs two-phase-on, so leave a single-coil phase first
                    if (!half_step && !r_index[0]) begin
                        w_index_nxt = cmd_dir ? (r_index + 3'd1) : (r_index - 3'd1);
                    end
                end
            end
        end else begin
            if (abort || (r_steps_left == '0)) begin
                w_state_nxt = c_IDLE;
                w_done_nxt  = 1'b1;
            end else if (r_period_cnt == '0) begin
                if (w_limit_hit) begin
                    w_state_nxt = c_IDLE;
                    w_done_nxt  = 1'b1;
                    w_fault_nxt = 1'b1;
                end else begin
                    w_index_nxt = r_dir ? (r_index + w_idx_delta) : (r_index - w_idx_delta);
                    w_pos_nxt   = r_dir ? (r_position + w_pos_delta) : (r_position - w_pos_delta);
                    w_steps_nxt = r_steps_left - c_CNT_ONE;
                    w_cnt_nxt   = r_reload;
                end
            end else begin
                w_cnt_nxt = r_period_cnt - c_CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= c_IDLE;
            r_index        <= 3'd0;
            r_position     <= '0;
            r_steps_left   <= '0;
            r_period_cnt   <= '0;
            r_reload       <= '0;
            r_dir          <= 1'b0;
            r_half         <= 1'b0;
            r_done         <= 1'b0;
            r_fault        <= 1'b0;
            r_coils        <= 4'b0000;
            r_lim_pos_meta <= 1'b0;
            r_lim_pos_sync <= 1'b0;
            r_lim_neg_meta <= 1'b0;
            r_lim_neg_sync <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_index        <= w_index_nxt;
            r_position     <= w_pos_nxt;
            r_steps_left   <= w_steps_nxt;
            r_period_cnt   <= w_cnt_nxt;
            r_reload       <= w_reload_nxt;
            r_dir          <= w_dir_nxt;
            r_half         <= w_half_nxt;
            r_done         <= w_done_nxt;
            r_fault        <= w_fault_nxt;
            r_coils        <= ((w_state_nxt == c_RUN) || hold_en) ? f_phase(w_index_nxt) : 4'b0000;
            r_lim_pos_meta <= limit_pos;
            r_lim_pos_sync <= r_lim_pos_meta;
            r_lim_neg_meta <= limit_neg;
            r_lim_neg_sync <= r_lim_neg_meta;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_step_motor_phase_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_step_motor_phase_gen
//  Purpose  : Directed self-checking bench for step_motor_phase_gen.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_step_motor_phase_gen;

    localparam int CNT_W = 16;
    localparam int POS_W = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             cmd_valid;
    logic [CNT_W-1:0] cmd_steps;
    logic             cmd_dir;
    logic [CNT_W-1:0] cmd_period;
    logic             half_step;
    logic             hold_en;
    logic             abort;
    logic             pos_clr;
    logic             limit_pos;
    logic             limit_neg;
    wire              cmd_ready;
    wire              AX, AY, BX, BY;
    wire              busy;
    wire              done;
    wire              fault_limit;
    wire  [POS_W-1:0] position;
    wire  [3:0]       coils = {AX, AY, BX, BY};

    int total = 0;
    int bad   = 0;

    step_motor_phase_gen #(.CNT_W(CNT_W), .POS_W(POS_W)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_steps(cmd_steps), .cmd_dir(cmd_dir), .cmd_period(cmd_period),
        .half_step(half_step), .hold_en(hold_en), .abort(abort), .pos_clr(pos_clr),
        .limit_pos(limit_pos), .limit_neg(limit_neg),
        .AX(AX), .AY(AY), .BX(BX), .BY(BY),
        .busy(busy), .done(done), .fault_limit(fault_limit), .position(position)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1; cmd_valid = 1'b0; abort = 1'b0; pos_clr = 1'b0;
        limit_pos = 1'b0; limit_neg = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
    endtask

    // Leaves the bench one step past the accept edge (k = 0)
    task automatic start_cmd(input int steps, input bit dir, input int period, input bit half);
        cmd_steps  = steps[CNT_W-1:0];
        cmd_period = period[CNT_W-1:0];
        cmd_dir    = dir;
        half_step  = half;
        cmd_valid  = 1'b1;
        tick();
        cmd_valid  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; cmd_valid = 1'b0; cmd_steps = '0; cmd_dir = 1'b0; cmd_period = '0;
        half_step = 1'b0; hold_en = 1'b1; abort = 1'b0; pos_clr = 1'b0;
        limit_pos = 1'b0; limit_neg = 1'b0;
        tick(); tick();
        total++; if (coils !== 4'b0000) begin bad++; $display("FAIL reset_coils got=%b exp=0000", coils); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (fault_limit !== 1'b0) begin bad++; $display("FAIL reset_fault got=%b exp=0", fault_limit); end
        total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", cmd_ready); end
        total++; if (position !== 32'd0) begin bad++; $display("FAIL reset_pos got=%h exp=0", position); end
        reset = 1'b0;
        tick();
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL idle_ready got=%b exp=1", cmd_ready); end
        total++; if (coils !== 4'b1000) begin bad++; $display("FAIL idle_hold_coils got=%b exp=1000", coils); end
    endtask

    task automatic test_half_step();
        logic [3:0] exp_c;
        apply_reset();
        hold_en = 1'b1;
        start_cmd(3, 1'b1, 4, 1'b1);
        for (int k = 0; k <= 13; k++) begin
            if (k > 0) tick();
            exp_c = (k < 4) ? 4'b1000 : (k < 8) ? 4'b1010 : (k < 12) ? 4'b0010 : 4'b0110;
            total++; if (coils !== exp_c) begin bad++; $display("FAIL half_coils k=%0d got=%b exp=%b", k, coils, exp_c); end
            total++; if (done !== (k == 13)) begin bad++; $display("FAIL half_done k=%0d got=%b exp=%b", k, done, (k == 13)); end
            total++; if (busy !== (k < 13)) begin bad++; $display("FAIL half_busy k=%0d got=%b exp=%b", k, busy, (k < 13)); end
        end
        total++; if (position !== 32'd3) begin bad++; $display("FAIL half_pos got=%h exp=3", position); end
    endtask

    task automatic test_full_step();
        apply_reset();
        hold_en = 1'b1;
        start_cmd(2, 1'b0, 2, 1'b0);
        total++; if (coils !== 4'b1001) begin bad++; $display("FAIL full_round got=%b exp=1001", coils); end
        total++; if (position !== 32'd0) begin bad++; $display("FAIL full_round_pos got=%h exp=0", position); end
        tick(); tick();
        total++; if (coils !== 4'b0101) begin bad++; $display("FAIL full_step1 got=%b exp=0101", coils); end
        tick(); tick();
        total++; if (coils !== 4'b0110) begin bad++; $display("FAIL full_step2 got=%b exp=0110", coils); end
        tick();
        total++; if (done !== 1'b1) begin bad++; $display("FAIL full_done got=%b exp=1", done); end
        total++; if (position !== 32'hFFFF_FFFC) begin bad++; $display("FAIL full_pos got=%h exp=fffffffc", position); end
    endtask

    task automatic test_limit();
        int  n;
        bit  seen;
        apply_reset();
        hold_en   = 1'b1;
        limit_neg = 1'b1;
        start_cmd(100, 1'b1, 10, 1'b1);
        repeat (50) tick();
        total++; if (position !== 32'd5) begin bad++; $display("FAIL limit_neg_ignored pos got=%h exp=5", position); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL limit_busy got=%b exp=1", busy); end
        limit_pos = 1'b1;
        seen = 1'b0; n = 0;
        for (int i = 1; i <= 14; i++) begin
            tick();
            if (done === 1'b1) begin seen = 1'b1; n = i; break; end
        end
        total++; if (!seen || n > 12) begin bad++; $display("FAIL limit_stop seen=%0d cycles=%0d exp<=12", seen, n); end
        total++; if (fault_limit !== 1'b1) begin bad++; $display("FAIL limit_fault got=%b exp=1", fault_limit); end
        total++; if (position !== 32'd5) begin bad++; $display("FAIL limit_pos got=%h exp=5", position); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL limit_idle busy got=%b exp=0", busy); end
        limit_pos = 1'b0; limit_neg = 1'b0;
        tick(); tick(); tick();
        total++; if (fault_limit !== 1'b1) begin bad++; $display("FAIL limit_sticky got=%b exp=1", fault_limit); end
    endtask

    task automatic test_abort_zero();
        start_cmd(5, 1'b1, 3, 1'b1);
        total++; if (fault_limit !== 1'b0) begin bad++; $display("FAIL accept_clears_fault got=%b exp=0", fault_limit); end
        tick(); tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        total++; if (done !== 1'b1) begin bad++; $display("FAIL abort_done got=%b exp=1", done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
        total++; if (position !== 32'd5) begin bad++; $display("FAIL abort_pos got=%h exp=5", position); end
        total++; if (coils !== 4'b0101) begin bad++; $display("FAIL abort_coils got=%b exp=0101", coils); end
        tick();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL abort_done_pulse got=%b exp=0", done); end
        start_cmd(0, 1'b1, 5, 1'b1);
        total++; if (done !== 1'b1) begin bad++; $display("FAIL zero_done got=%b exp=1", done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL zero_busy got=%b exp=0", busy); end
        tick();
        total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL zero_after done=%b busy=%b exp=0/0", done, busy); end
    endtask

    task automatic test_idle_controls();
        hold_en = 1'b0;
        tick(); tick();
        total++; if (coils !== 4'b0000) begin bad++; $display("FAIL nohold_coils got=%b exp=0000", coils); end
        start_cmd(2, 1'b1, 0, 1'b1);
        total++; if (coils !== 4'b0101) begin bad++; $display("FAIL run_coils got=%b exp=0101", coils); end
        pos_clr = 1'b1;
        tick();
        pos_clr = 1'b0;
        total++; if (position !== 32'd5) begin bad++; $display("FAIL busy_posclr got=%h exp=5", position); end
        tick();
        total++; if (position !== 32'd6 || coils !== 4'b0001) begin bad++; $display("FAIL period0_step1 pos=%h coils=%b exp=6/0001", position, coils); end
        tick(); tick();
        total++; if (position !== 32'd7 || coils !== 4'b1001) begin bad++; $display("FAIL period0_step2 pos=%h coils=%b exp=7/1001", position, coils); end
        tick();
        total++; if (done !== 1'b1 || coils !== 4'b0000) begin bad++; $display("FAIL idle_release done=%b coils=%b exp=1/0000", done, coils); end
        pos_clr = 1'b1;
        tick();
        pos_clr = 1'b0;
        total++; if (position !== 32'd0) begin bad++; $display("FAIL idle_posclr got=%h exp=0", position); end
    endtask

    task automatic test_wrap();
        hold_en = 1'b1;
        tick();
        force dut.r_position = 32'h7FFF_FFFF;
        #2;
        release dut.r_position;
        tick();
        total++; if (position !== 32'h7FFF_FFFF) begin bad++; $display("FAIL wrap_preload got=%h exp=7fffffff", position); end
        start_cmd(1, 1'b1, 2, 1'b1);
        tick(); tick();
        total++; if (position !== 32'h8000_0000) begin bad++; $display("FAIL wrap_pos got=%h exp=80000000", position); end
        tick();
        total++; if (done !== 1'b1) begin bad++; $display("FAIL wrap_done got=%b exp=1", done); end
    endtask

    task automatic test_reset_mid_move();
        bit done_seen;
        hold_en = 1'b1;
        start_cmd(10, 1'b1, 3, 1'b1);
        repeat (4) tick();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL midrst_pre_busy got=%b exp=1", busy); end
        #2 reset = 1'b1;
        #1;
        total++; if (coils !== 4'b0000) begin bad++; $display("FAIL midrst_coils got=%b exp=0000", coils); end
        total++; if (busy !== 1'b0 || cmd_ready !== 1'b0) begin bad++; $display("FAIL midrst_busy busy=%b ready=%b exp=0/0", busy, cmd_ready); end
        total++; if (position !== 32'd0) begin bad++; $display("FAIL midrst_pos got=%h exp=0", position); end
        done_seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (done !== 1'b0) done_seen = 1'b1;
            tick();
        end
        total++; if (done_seen) begin bad++; $display("FAIL midrst_done got=1 exp=0"); end
        reset = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_half_step();
        test_full_step();
        test_limit();
        test_abort_zero();
        test_idle_controls();
        test_wrap();
        test_reset_mid_move();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
